// File: rtl/spi_device.sv
// SPI target endpoint: oversampled SCK/CS_n/MOSI pins, one byte per 8 SCK cycles, valid/ready byte streams.
// Optional sticky overrun/underrun status flags are built only when SPI_DEVICE_STATUS_EN is defined.
`timescale 1ns/1ps
module spi_device #(
    parameter logic       CPOL     = 1'b0,
    parameter logic       CPHA     = 1'b0,
    parameter logic [7:0] IdleByte = 8'hFF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       sck_i,
    input  logic       cs_ni,
    input  logic       mosi_i,
    output logic       miso_o,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    output logic       active_o
`ifdef SPI_DEVICE_STATUS_EN
    ,
    output logic       rx_overrun_o,
    output logic       tx_underrun_o,
    input  logic       status_clr_i
`endif
);

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_e;

    state_e     state_q, state_d;
    logic [1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
    logic       sck_prev_q;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] rx_sr_q, rx_sr_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic [7:0] tx_sr_q, tx_sr_d;
    logic [7:0] buf_q, buf_d;
    logic       buf_full_q, buf_full_d;

    logic sck_s, cs_act, mosi_s;
    logic in_frame, lead_edge, trail_edge, sample_edge, shift_edge;
    logic cs_assert, cs_deassert, load_pt, byte_done, tx_accept;

    // Two-stage synchronisers plus the delayed SCK copy used for edge detection
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sck_sync_q  <= {2{CPOL}};
            cs_sync_q   <= 2'b11;
            mosi_sync_q <= 2'b00;
            sck_prev_q  <= CPOL;
        end else begin
            sck_sync_q  <= {sck_sync_q[0], sck_i};
            cs_sync_q   <= {cs_sync_q[0], cs_ni};
            mosi_sync_q <= {mosi_sync_q[0], mosi_i};
            sck_prev_q  <= sck_sync_q[1];
        end
    end

    assign sck_s  = sck_sync_q[1];
    assign cs_act = ~cs_sync_q[1];
    assign mosi_s = mosi_sync_q[1];

    assign in_frame    = (state_q == ST_ACTIVE) && cs_act;
    assign lead_edge   = in_frame && (sck_s != CPOL) && (sck_prev_q == CPOL);
    assign trail_edge  = in_frame && (sck_s == CPOL) && (sck_prev_q != CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;
    assign cs_assert   = (state_q == ST_IDLE) && cs_act;
    assign cs_deassert = (state_q == ST_ACTIVE) && !cs_act;
    assign load_pt     = (shift_edge && (bit_cnt_q == 3'd0)) || (!CPHA && cs_assert);
    assign byte_done   = sample_edge && (bit_cnt_q == 3'd7);
    assign tx_accept   = tx_valid_i && !buf_full_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd0;
            rx_sr_q    <= 7'd0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            tx_sr_q    <= 8'hFF;
            buf_q      <= 8'h00;
            buf_full_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_sr_q    <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_sr_q    <= tx_sr_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        tx_sr_d    = tx_sr_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;

        case (state_q)
            ST_IDLE:   if (cs_act)  state_d = ST_ACTIVE;
            ST_ACTIVE: if (!cs_act) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        if (sample_edge) begin
            rx_sr_d   = {rx_sr_q[5:0], mosi_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
        end

        if (byte_done) begin
            rx_data_d  = {rx_sr_q, mosi_s};
            rx_valid_d = 1'b1;
        end else if (rx_ready_i) begin
            rx_valid_d = 1'b0;
        end

        if (tx_accept) begin
            buf_d      = tx_data_i;
            buf_full_d = 1'b1;
        end

        // A write arriving on an empty buffer at a load point goes straight to the shifter
        if (load_pt) begin
            if (buf_full_q) begin
                tx_sr_d    = buf_q;
                buf_full_d = 1'b0;
            end else if (tx_accept) begin
                tx_sr_d    = tx_data_i;
                buf_full_d = 1'b0;
            end else begin
                tx_sr_d = IdleByte;
            end
        end else if (shift_edge) begin
            tx_sr_d = {tx_sr_q[6:0], 1'b1};
        end

        if (CPHA && cs_assert) begin
            tx_sr_d = 8'hFF;
        end

        if (cs_deassert) begin
            bit_cnt_d = 3'd0;
            rx_sr_d   = 7'd0;
            tx_sr_d   = 8'hFF;
        end
    end

    assign miso_o     = (state_q == ST_ACTIVE) ? tx_sr_q[7] : 1'b1;
    assign tx_ready_o = !buf_full_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign active_o   = (state_q == ST_ACTIVE);

`ifdef SPI_DEVICE_STATUS_EN
    logic ovr_q, ovr_d, und_q, und_d, ovr_evt, und_evt;

    assign ovr_evt = byte_done && rx_valid_q && !rx_ready_i;
    assign und_evt = load_pt && !buf_full_q && !tx_accept;

    // A set event in the same cycle as a clear leaves the flag set
    always_comb begin
        ovr_d = ovr_q;
        und_d = und_q;
        if (status_clr_i) begin
            ovr_d = 1'b0;
            und_d = 1'b0;
        end
        if (ovr_evt) ovr_d = 1'b1;
        if (und_evt) und_d = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovr_q <= 1'b0;
            und_q <= 1'b0;
        end else begin
            ovr_q <= ovr_d;
            und_q <= und_d;
        end
    end

    assign rx_overrun_o  = ovr_q;
    assign tx_underrun_o = und_q;
`endif

endmodule

// File: tb/tb_spi_device.sv
// Bench for spi_device: a mode-0 instance and a CPOL=1/CPHA=1 instance driven by a bit-level SPI host.
// Expected bytes come from a frame-level model of buffer loads, idle-byte fill and received bytes.
`timescale 1ns/1ps
module tb_spi_device;

    localparam int HALF = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [1:0] sck, csN, txValid, rxReady;
    logic       mosi;
    logic [7:0] txData;
    logic       miso0, miso1, txReady0, txReady1, rxValid0, rxValid1, active0, active1;
    logic [7:0] rxData0, rxData1;
`ifdef SPI_DEVICE_STATUS_EN
    logic       statusClr;
    logic       ovr0, ovr1, und0, und1;
`endif

    int passCount = 0;
    int checkCount = 0;

    logic [7:0] hostTx [4];
    logic [7:0] feedTx [4];
    logic [7:0] gotRx [4];
    logic       hostRxBit [32];
    int         gotCount;
    bit         frameDone;

    logic [7:0] mRxData [2];
    bit         mRxValid [2];
    bit         mOvr [2];
    bit         mUnd [2];

    spi_device #(.CPOL(1'b0), .CPHA(1'b0), .IdleByte(8'hFF)) dut0 (
        .clk_i(clk), .rst_i(rst), .sck_i(sck[0]), .cs_ni(csN[0]), .mosi_i(mosi),
        .miso_o(miso0), .tx_data_i(txData), .tx_valid_i(txValid[0]), .tx_ready_o(txReady0),
        .rx_data_o(rxData0), .rx_valid_o(rxValid0), .rx_ready_i(rxReady[0]), .active_o(active0)
`ifdef SPI_DEVICE_STATUS_EN
        , .rx_overrun_o(ovr0), .tx_underrun_o(und0), .status_clr_i(statusClr)
`endif
    );

    spi_device #(.CPOL(1'b1), .CPHA(1'b1), .IdleByte(8'hFF)) dut1 (
        .clk_i(clk), .rst_i(rst), .sck_i(sck[1]), .cs_ni(csN[1]), .mosi_i(mosi),
        .miso_o(miso1), .tx_data_i(txData), .tx_valid_i(txValid[1]), .tx_ready_o(txReady1),
        .rx_data_o(rxData1), .rx_valid_o(rxValid1), .rx_ready_i(rxReady[1]), .active_o(active1)
`ifdef SPI_DEVICE_STATUS_EN
        , .rx_overrun_o(ovr1), .tx_underrun_o(und1), .status_clr_i(statusClr)
`endif
    );

    function automatic logic misoOf(input int sel);
        return (sel != 0) ? miso1 : miso0;
    endfunction

    function automatic logic txReadyOf(input int sel);
        return (sel != 0) ? txReady1 : txReady0;
    endfunction

    function automatic logic rxValidOf(input int sel);
        return (sel != 0) ? rxValid1 : rxValid0;
    endfunction

    function automatic logic [7:0] rxDataOf(input int sel);
        return (sel != 0) ? rxData1 : rxData0;
    endfunction

    function automatic logic activeOf(input int sel);
        return (sel != 0) ? active1 : active0;
    endfunction

    function automatic logic hostBit(input int b);
        logic [7:0] t;
        t = hostTx[b / 8];
        return t[3'(7 - (b % 8))];
    endfunction

    task automatic clocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    task automatic writeByte(input int sel, input logic [7:0] data);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!txReadyOf(sel) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) begin
            checkOutput("txReadyTimeout", 32'd0, 32'd1);
        end else begin
            txData = data;
            txValid[sel] = 1'b1;
            @(negedge clk);
            txValid[sel] = 1'b0;
        end
    endtask

    task automatic readOne(input int sel);
        rxReady[sel] = 1'b1;
        @(negedge clk);
        rxReady[sel] = 1'b0;
        mRxValid[sel] = 1'b0;
        checkOutput("rxValidCleared", 32'(rxValidOf(sel)), 32'd0);
    endtask

    task automatic clearFlags();
`ifdef SPI_DEVICE_STATUS_EN
        statusClr = 1'b1;
        @(negedge clk);
        statusClr = 1'b0;
        for (int s = 0; s < 2; s++) begin
            mOvr[s] = 1'b0;
            mUnd[s] = 1'b0;
        end
        checkOutput("ovrCleared", {30'd0, ovr1, ovr0}, 32'd0);
        checkOutput("undCleared", {30'd0, und1, und0}, 32'd0);
`endif
    endtask

    task automatic modelReset();
        for (int s = 0; s < 2; s++) begin
            mRxData[s]  = 8'h00;
            mRxValid[s] = 1'b0;
            mOvr[s]     = 1'b0;
            mUnd[s]     = 1'b0;
        end
    endtask

    // Host drives one CS frame of nbits bits; a feeder keeps the TX buffer topped up and an optional reader drains RX
    task automatic applyStimulus(input int sel, input int nbits, input int nFeed, input bit autoRead);
        logic cpol, cpha;
        int   guard;
        cpol = (sel != 0);
        cpha = (sel != 0);
        gotCount = 0;
        frameDone = 1'b0;
        if (nFeed > 0) writeByte(sel, feedTx[0]);
        fork
            begin
                csN[sel] = 1'b0;
                if (!cpha) mosi = hostBit(0);
                clocks(6);
                checkOutput("activeInFrame", 32'(activeOf(sel)), 32'd1);
                if (!cpha) checkOutput("txReadyAfterCsLoad", 32'(txReadyOf(sel)), (nFeed >= 2) ? 32'd0 : 32'd1);
                else checkOutput("misoBeforeFirstEdge", 32'(misoOf(sel)), 32'd1);
                for (int b = 0; b < nbits; b++) begin
                    if (!cpha) begin
                        sck[sel] = ~cpol;
                        hostRxBit[b] = misoOf(sel);
                        clocks(HALF);
                        sck[sel] = cpol;
                        if (b + 1 < nbits) mosi = hostBit(b + 1);
                        clocks(HALF);
                    end else begin
                        sck[sel] = ~cpol;
                        mosi = hostBit(b);
                        clocks(HALF);
                        sck[sel] = cpol;
                        hostRxBit[b] = misoOf(sel);
                        clocks(HALF);
                    end
                end
                csN[sel] = 1'b1;
                clocks(8);
                frameDone = 1'b1;
            end
            begin
                for (int j = 1; j < nFeed; j++) writeByte(sel, feedTx[j]);
            end
            begin
                guard = 0;
                while (!frameDone && guard < 5000) begin
                    @(negedge clk);
                    guard++;
                    if (autoRead) begin
                        if (rxReady[sel]) begin
                            rxReady[sel] = 1'b0;
                        end else if (rxValidOf(sel)) begin
                            if (gotCount < 4) gotRx[gotCount] = rxDataOf(sel);
                            gotCount++;
                            rxReady[sel] = 1'b1;
                        end
                    end
                end
                rxReady[sel] = 1'b0;
            end
        join
    endtask

    // Frame-level model: every load point takes the next fed byte or the idle byte
    task automatic checkFrame(input string tag, input int sel, input int nbits, input int nFeed, input bit autoRead);
        int         nb, rem, nLoads;
        logic [7:0] loads [5];
        logic [7:0] got;
        nb  = nbits / 8;
        rem = nbits % 8;
        nLoads = (sel != 0) ? (nbits + 7) / 8 : 1 + nb;
        for (int j = 0; j < nLoads; j++) begin
            if (j < nFeed) loads[j] = feedTx[j];
            else begin
                loads[j] = 8'hFF;
                mUnd[sel] = 1'b1;
            end
        end
        for (int b = 0; b < nb; b++) begin
            got = 8'h00;
            for (int i = 0; i < 8; i++) got = {got[6:0], hostRxBit[8 * b + i]};
            checkOutput({tag, "/hostRx"}, 32'(got), 32'(loads[b]));
        end
        if (rem > 0) begin
            got = 8'h00;
            for (int i = 0; i < rem; i++) got = {got[6:0], hostRxBit[8 * nb + i]};
            checkOutput({tag, "/hostRxPartial"}, 32'(got), 32'(loads[nb] >> (8 - rem)));
        end
        if (autoRead) begin
            checkOutput({tag, "/rxCount"}, 32'(gotCount), 32'(nb));
            for (int b = 0; b < nb && b < gotCount && b < 4; b++)
                checkOutput({tag, "/rxByte"}, 32'(gotRx[b]), 32'(hostTx[b]));
        end else begin
            for (int b = 0; b < nb; b++) begin
                if (mRxValid[sel]) mOvr[sel] = 1'b1;
                mRxValid[sel] = 1'b1;
            end
        end
        if (nb > 0) mRxData[sel] = hostTx[nb - 1];
        checkOutput({tag, "/rxData"}, 32'(rxDataOf(sel)), 32'(mRxData[sel]));
        checkOutput({tag, "/rxValid"}, 32'(rxValidOf(sel)), 32'(mRxValid[sel]));
        checkOutput({tag, "/txReady"}, 32'(txReadyOf(sel)), 32'd1);
        checkOutput({tag, "/misoIdle"}, 32'(misoOf(sel)), 32'd1);
        checkOutput({tag, "/activeIdle"}, 32'(activeOf(sel)), 32'd0);
`ifdef SPI_DEVICE_STATUS_EN
        checkOutput({tag, "/overrun"}, 32'((sel != 0) ? ovr1 : ovr0), 32'(mOvr[sel]));
        checkOutput({tag, "/underrun"}, 32'((sel != 0) ? und1 : und0), 32'(mUnd[sel]));
`endif
    endtask

    initial begin
        int sel, nb, nLoads, nFeed;
        bit autoRead;

        rst = 1'b1;
        sck = 2'b10;
        csN = 2'b11;
        txValid = 2'b00;
        rxReady = 2'b00;
        mosi = 1'b0;
        txData = 8'h00;
`ifdef SPI_DEVICE_STATUS_EN
        statusClr = 1'b0;
`endif
        modelReset();
        clocks(3);
        for (int s = 0; s < 2; s++) begin
            checkOutput("resetMiso", 32'(misoOf(s)), 32'd1);
            checkOutput("resetTxReady", 32'(txReadyOf(s)), 32'd1);
            checkOutput("resetActive", 32'(activeOf(s)), 32'd0);
            checkOutput("resetRxValid", 32'(rxValidOf(s)), 32'd0);
            checkOutput("resetRxData", 32'(rxDataOf(s)), 32'd0);
        end
        clearFlags();
        rst = 1'b0;
        clocks(4);

        $display("[TB] mode 0: device sends A5, host sends 3C");
        hostTx[0] = 8'h3C;
        feedTx[0] = 8'hA5;
        applyStimulus(0, 8, 1, 1'b0);
        checkFrame("m0basic", 0, 8, 1, 1'b0);
        readOne(0);
        clearFlags();

        $display("[TB] mode 3: two bytes under one CS");
        hostTx[0] = 8'h81; hostTx[1] = 8'h7E;
        feedTx[0] = 8'h12; feedTx[1] = 8'h34;
        applyStimulus(1, 16, 2, 1'b1);
        checkFrame("m3pair", 1, 16, 2, 1'b1);

        $display("[TB] mode 3: buffer empty at second load");
        hostTx[0] = 8'h55; hostTx[1] = 8'hAA;
        feedTx[0] = 8'h5A;
        applyStimulus(1, 16, 1, 1'b1);
        checkFrame("m3underrun", 1, 16, 1, 1'b1);
        clearFlags();

        $display("[TB] mode 0: two bytes without reading");
        hostTx[0] = 8'h11; hostTx[1] = 8'h22;
        feedTx[0] = 8'h0F; feedTx[1] = 8'hF0; feedTx[2] = 8'h3A;
        applyStimulus(0, 16, 3, 1'b0);
        checkFrame("m0overrun", 0, 16, 3, 1'b0);
        readOne(0);
        clearFlags();

        $display("[TB] mode 0: partial byte then a full byte");
        hostTx[0] = 8'($urandom);
        feedTx[0] = 8'($urandom);
        applyStimulus(0, 5, 1, 1'b1);
        checkFrame("m0partial", 0, 5, 1, 1'b1);
        hostTx[0] = 8'hC3;
        feedTx[0] = 8'($urandom);
        applyStimulus(0, 8, 1, 1'b1);
        checkFrame("m0afterPartial", 0, 8, 1, 1'b1);
        clearFlags();

        for (int r = 0; r < 6; r++) begin
            sel = int'($urandom_range(0, 1));
            nb = int'($urandom_range(1, 3));
            nLoads = (sel != 0) ? nb : nb + 1;
            nFeed = int'($urandom_range(0, nLoads));
            autoRead = 1'($urandom_range(0, 1));
            for (int j = 0; j < 4; j++) begin
                hostTx[j] = 8'($urandom);
                feedTx[j] = 8'($urandom);
            end
            applyStimulus(sel, 8 * nb, nFeed, autoRead);
            checkFrame($sformatf("rnd%0d", r), sel, 8 * nb, nFeed, autoRead);
            if (!autoRead) readOne(sel);
            clearFlags();
        end

        $display("[TB] reset in the middle of a byte");
        writeByte(0, 8'h96);
        csN[0] = 1'b0;
        mosi = 1'b1;
        clocks(6);
        writeByte(0, 8'h69);
        for (int b = 0; b < 3; b++) begin
            sck[0] = 1'b1;
            clocks(HALF);
            sck[0] = 1'b0;
            clocks(HALF);
        end
        checkOutput("preResetTxReady", 32'(txReady0), 32'd0);
        rst = 1'b1;
        #1;
        checkOutput("midResetMiso", 32'(miso0), 32'd1);
        checkOutput("midResetTxReady", 32'(txReady0), 32'd1);
        checkOutput("midResetActive", 32'(active0), 32'd0);
        checkOutput("midResetRxValid", 32'(rxValid0), 32'd0);
        checkOutput("midResetRxData", 32'(rxData0), 32'd0);
        csN[0] = 1'b1;
        sck[0] = 1'b0;
        mosi = 1'b0;
        modelReset();
        clocks(2);
        rst = 1'b0;
        clocks(4);
        hostTx[0] = 8'($urandom);
        feedTx[0] = 8'($urandom);
        applyStimulus(0, 8, 1, 1'b1);
        checkFrame("afterReset", 0, 8, 1, 1'b1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
